// File: rtl/micro_loader.sv
// micro_loader: UART byte-stream program loader and run/step sequencer
// for the 16-bit micro core instruction RAM.
module micro_loader #(
  parameter int WIDTH          = 16,
  parameter int IRAM_ADDR_BITS = 8,
  parameter int TICK_DIV       = 25000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  input  logic                      cmd_load,
  input  logic                      cmd_halt,
  input  logic                      cmd_run,
  input  logic                      cmd_step,
  output logic [IRAM_ADDR_BITS-1:0] iram_wa,
  output logic                      iram_wen,
  output logic [WIDTH-1:0]          iram_din,
  output logic                      core_reset,
  output logic                      PCenable,
  output logic [1:0]                state,
  output logic [IRAM_ADDR_BITS:0]   words_loaded
);

  localparam int AW = IRAM_ADDR_BITS;
  localparam int CW = AW + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] FULL  = ONE << AW;
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HALT = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    P_COUNT = 2'd0,
    P_HI    = 2'd1,
    P_LO    = 2'd2
  } phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [3:0]      cmd_sync_q, cmd_last_q;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   words_q, words_d;
  logic [7:0]      hi_q, hi_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic            wen_q, wen_d;
  logic            rdy_q, rdy_d;
  logic            crst_q, crst_d;
  logic            pcen_q, pcen_d;

  logic [3:0] rise;
  logic       ld, ht, rn, st, acc;
  logic [CW-1:0] words_inc;

  assign rise = cmd_sync_q & ~cmd_last_q;
  assign ld   = rise[0];
  assign ht   = rise[1];
  assign rn   = rise[2];
  assign st   = rise[3];
  assign acc  = rx_valid && rdy_q;
  assign words_inc = words_q + ONE;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    words_d = words_q;
    hi_d    = hi_q;
    tick_d  = tick_q;
    wa_d    = wa_q;
    din_d   = din_q;
    wen_d   = 1'b0;
    rdy_d   = rdy_q;
    crst_d  = crst_q;
    pcen_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        crst_d = 1'b1;
        rdy_d  = 1'b0;
        if (ld) begin
          state_d = S_LOAD;
          rdy_d   = 1'b1;
          words_d = '0;
          phase_d = P_COUNT;
        end else if (ht || st) begin
          state_d = S_HALT;
          crst_d  = 1'b0;
        end else if (rn) begin
          state_d = S_RUN;
          crst_d  = 1'b0;
          tick_d  = '0;
        end
      end
      S_LOAD: begin
        crst_d = 1'b1;
        if (acc) begin
          unique case (phase_q)
            P_COUNT: begin
              count_d = (rx_data == 8'd0) ? FULL : CW'(rx_data);
              phase_d = P_HI;
            end
            P_HI: begin
              hi_d    = rx_data;
              phase_d = P_LO;
            end
            P_LO: begin
              wen_d   = 1'b1;
              din_d   = WIDTH'({hi_q, rx_data});
              wa_d    = words_q[AW-1:0];
              words_d = words_inc;
              phase_d = P_HI;
              if (words_inc == count_q) rdy_d = 1'b0;
            end
            default: phase_d = P_COUNT;
          endcase
        end
        // final word is on the RAM port this cycle
        if (wen_q && words_q == count_q) begin
          state_d = S_HALT;
          crst_d  = 1'b0;
          rdy_d   = 1'b0;
        end
        if (ld) begin
          rdy_d   = 1'b1;
          crst_d  = 1'b1;
          state_d = S_LOAD;
          words_d = '0;
          phase_d = P_COUNT;
          wen_d   = 1'b0;
        end else if (ht) begin
          state_d = S_IDLE;
          rdy_d   = 1'b0;
          crst_d  = 1'b1;
        end
      end
      S_HALT: begin
        crst_d = 1'b0;
        if (ld) begin
          state_d = S_LOAD;
          rdy_d   = 1'b1;
          crst_d  = 1'b1;
          words_d = '0;
          phase_d = P_COUNT;
        end else if (ht) begin
          state_d = S_HALT;
        end else if (st) begin
          pcen_d = 1'b1;
        end else if (rn) begin
          state_d = S_RUN;
          tick_d  = '0;
        end
      end
      S_RUN: begin
        crst_d = 1'b0;
        if (ld) begin
          state_d = S_LOAD;
          rdy_d   = 1'b1;
          crst_d  = 1'b1;
          words_d = '0;
          phase_d = P_COUNT;
        end else if (ht) begin
          state_d = S_HALT;
        end else if (tick_q == TLAST) begin
          tick_d = '0;
          pcen_d = 1'b1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      phase_q    <= P_COUNT;
      cmd_sync_q <= '0;
      cmd_last_q <= '0;
      count_q    <= '0;
      words_q    <= '0;
      hi_q       <= '0;
      tick_q     <= '0;
      wa_q       <= '0;
      din_q      <= '0;
      wen_q      <= 1'b0;
      rdy_q      <= 1'b0;
      crst_q     <= 1'b1;
      pcen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cmd_sync_q <= {cmd_step, cmd_run, cmd_halt, cmd_load};
      cmd_last_q <= cmd_sync_q;
      count_q    <= count_d;
      words_q    <= words_d;
      hi_q       <= hi_d;
      tick_q     <= tick_d;
      wa_q       <= wa_d;
      din_q      <= din_d;
      wen_q      <= wen_d;
      rdy_q      <= rdy_d;
      crst_q     <= crst_d;
      pcen_q     <= pcen_d;
    end
  end

  assign rx_ready     = rdy_q;
  assign iram_wa      = wa_q;
  assign iram_wen     = wen_q;
  assign iram_din     = din_q;
  assign core_reset   = crst_q;
  assign PCenable     = pcen_q;
  assign state        = state_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_micro_loader.sv
// tb_micro_loader: scoreboard bench for micro_loader (TICK_DIV=4 main
// instance, TICK_DIV=1 companion instance on the same stimulus).
module tb_micro_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_load, cmd_halt, cmd_run, cmd_step;

  logic        rdy0, wen0, crst0, pen0;
  logic [7:0]  wa0;
  logic [15:0] din0;
  logic [1:0]  st0;
  logic [8:0]  wl0;

  logic        rdy1, wen1, crst1, pen1;
  logic [7:0]  wa1;
  logic [15:0] din1;
  logic [1:0]  st1;
  logic [8:0]  wl1;

  micro_loader #(.WIDTH(16), .IRAM_ADDR_BITS(8), .TICK_DIV(4)) u0 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy0), .cmd_load(cmd_load), .cmd_halt(cmd_halt),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .iram_wa(wa0),
    .iram_wen(wen0), .iram_din(din0), .core_reset(crst0),
    .PCenable(pen0), .state(st0), .words_loaded(wl0)
  );

  micro_loader #(.WIDTH(16), .IRAM_ADDR_BITS(8), .TICK_DIV(1)) u1 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy1), .cmd_load(cmd_load), .cmd_halt(cmd_halt),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .iram_wa(wa1),
    .iram_wen(wen1), .iram_din(din1), .core_reset(crst1),
    .PCenable(pen1), .state(st1), .words_loaded(wl1)
  );

  int tests = 0;
  int fails = 0;
  int pc0 = 0;
  int pc1 = 0;
  int wen_cnt = 0;
  logic [23:0] sbq[$];
  logic [23:0] mon_exp;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // monitor: pops one expected write per RAM write strobe
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (pen0) pc0++;
      if (pen1) pc1++;
      if (wen0) begin
        wen_cnt++;
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected wa=%0h din=%0h", wa0, din0);
        end else begin
          mon_exp = sbq.pop_front();
          if ({wa0, din0} !== mon_exp) begin
            fails++;
            $display("FAIL sb_write got=%0h exp=%0h", {wa0, din0}, mon_exp);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit done;
    done = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rdy0) done = 1;
      tick(1);
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout byte=%0h", b);
    end
  endtask

  task automatic send_word(input logic [7:0] a, input logic [7:0] hi,
                           input logic [7:0] lo);
    sbq.push_back({a, hi, lo});
    send(hi);
    send(lo);
  endtask

  task automatic pulse(input int c);
    case (c)
      0: cmd_load = 1'b1;
      1: cmd_halt = 1'b1;
      2: cmd_run  = 1'b1;
      default: cmd_step = 1'b1;
    endcase
    tick(1);
    cmd_load = 1'b0;
    cmd_halt = 1'b0;
    cmd_run  = 1'b0;
    cmd_step = 1'b0;
    tick(1);
  endtask

  int p0, p1, w0;

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    cmd_load = 1'b0;
    cmd_halt = 1'b0;
    cmd_run  = 1'b0;
    cmd_step = 1'b0;
    #1 reset = 1'b0;
    #2;
    check("rst_state", st0, 0);
    check("rst_core_reset", crst0, 1);
    check("rst_pcen", pen0, 0);
    check("rst_wen", wen0, 0);
    check("rst_wa", wa0, 0);
    check("rst_din", din0, 0);
    check("rst_rx_ready", rdy0, 0);
    check("rst_words", wl0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick(2);

    // basic two-word load
    pulse(0);
    check("load_state", st0, 1);
    check("load_rx_ready", rdy0, 1);
    send(8'h02);
    send_word(8'd0, 8'h12, 8'h34);
    send_word(8'd1, 8'hAB, 8'hCD);
    rx_valid = 1'b0;
    check("load_rdy_drop", rdy0, 0);
    check("load_wen_last", wen0, 1);
    tick(1);
    check("load_halt", st0, 2);
    check("load_words", wl0, 2);
    check("load_core_reset", crst0, 0);
    check("load_wcount", wen_cnt, 2);

    // bytes outside LOAD are ignored
    w0 = wen_cnt;
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    tick(3);
    check("halt_rx_ready", rdy0, 0);
    rx_valid = 1'b0;
    tick(1);
    check("halt_no_write", wen_cnt, w0);

    // step: held level gives one pulse, re-press gives another
    p0 = pc0;
    cmd_step = 1'b1;
    tick(10);
    cmd_step = 1'b0;
    tick(2);
    check("step_held_one", pc0 - p0, 1);
    pulse(3);
    check("step_pulse_hi", pen0, 1);
    tick(1);
    check("step_pulse_lo", pen0, 0);
    check("step_total", pc0 - p0, 2);
    check("step_state", st0, 2);

    // run with divider 4 and 1
    pulse(2);
    check("run_state", st0, 3);
    check("run_core_reset", crst0, 0);
    p0 = pc0;
    p1 = pc1;
    tick(40);
    check("run_div4_pulses", pc0 - p0, 9);
    check("run_div1_pulses", pc1 - p1, 39);
    check("run_div4_hi", pen0, 1);
    check("run_div1_hi", pen1, 1);
    tick(1);
    check("run_div4_lo", pen0, 0);
    pulse(1);
    check("run_halt_state", st0, 2);
    check("run_halt_state1", st1, 2);
    p0 = pc0;
    p1 = pc1;
    tick(20);
    check("halt_no_pulse0", pc0 - p0, 0);
    check("halt_no_pulse1", pc1 - p1, 0);

    // abort after 1.5 words
    pulse(0);
    send(8'h03);
    send_word(8'd0, 8'h11, 8'h22);
    send(8'h33);
    rx_valid = 1'b0;
    tick(1);
    pulse(1);
    check("abort_state", st0, 0);
    check("abort_words", wl0, 1);
    check("abort_rx_ready", rdy0, 0);
    check("abort_core_reset", crst0, 1);

    // load beats halt in the same cycle
    cmd_load = 1'b1;
    cmd_halt = 1'b1;
    tick(1);
    cmd_load = 1'b0;
    cmd_halt = 1'b0;
    tick(1);
    check("prio_state", st0, 1);
    check("prio_words", wl0, 0);
    check("prio_rx_ready", rdy0, 1);
    send(8'h01);
    send_word(8'd0, 8'h55, 8'h66);
    rx_valid = 1'b0;
    tick(2);
    check("restart_state", st0, 2);
    check("restart_words", wl0, 1);

    // count byte 0 means a full 256-word image
    w0 = wen_cnt;
    pulse(0);
    send(8'h00);
    for (int i = 0; i < 256; i++)
      send_word(i[7:0], i[7:0], ~i[7:0]);
    rx_valid = 1'b0;
    tick(2);
    check("full_state", st0, 2);
    check("full_words", wl0, 256);
    check("full_writes", wen_cnt - w0, 256);
    check("full_last_wa", wa0, 8'hFF);

    // asynchronous reset between HI and LO
    pulse(0);
    send(8'h01);
    send(8'hAA);
    rx_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_state", st0, 0);
    check("arst_core_reset", crst0, 1);
    check("arst_rx_ready", rdy0, 0);
    check("arst_words", wl0, 0);
    check("arst_wa", wa0, 0);
    check("arst_din", din0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick(1);
    pulse(0);
    check("reload_state", st0, 1);
    send(8'h01);
    send_word(8'd0, 8'h77, 8'h88);
    rx_valid = 1'b0;
    tick(2);
    check("reload_state_halt", st0, 2);
    check("reload_words", wl0, 1);
    check("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/micro_loader.md
# micro_loader

Program loader and execution sequencer for the 16-bit `micro` core. It accepts a byte stream from a UART receiver over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes those words into the core's instruction RAM through `iram_wa`/`iram_wen`/`iram_din`, holding the core in reset while it does so. After loading, it drives the core's `reset` and `PCenable` for free-running, rate-divided or single-step execution.

## Interface
- `WIDTH`, 16, instruction word width (must be 16)
- `IRAM_ADDR_BITS`, 8, instruction RAM address width
- `TICK_DIV`, 25000000, RUN-mode clock cycles per PC advance (≥1)

- `clk` in 1: system clock, all logic on rising edge
- `reset` in 1: asynchronous, active-low reset
- `rx_data` in 8: received byte
- `rx_valid` in 1: `rx_data` valid
- `rx_ready` out 1: byte accepted when `rx_valid && rx_ready` at a rising edge
- `cmd_load`, `cmd_halt`, `cmd_run`, `cmd_step` in 1 each: command levels (debounced)
- `iram_wa` out IRAM_ADDR_BITS: instruction RAM write address
- `iram_wen` out 1: instruction RAM write enable
- `iram_din` out WIDTH: instruction RAM write data
- `core_reset` out 1: active-high reset to the core
- `PCenable` out 1: core program-counter enable
- `state` out 2: IDLE=0, LOAD=1, HALT=2, RUN=3
- `words_loaded` out IRAM_ADDR_BITS+1: words written in last/current load

## Operation
- All outputs are registered.
- Reset values:
  - `state`=IDLE, `core_reset`=1
  - `PCenable`=0, `iram_wen`=0, `iram_wa`=0, `iram_din`=0
  - `rx_ready`=0, `words_loaded`=0
  - internal tick counter=0, byte phase=COUNT
- Commands:
  - Each command is rising-edge detected internally, so a held level acts once.
  - Same-cycle priority: load > halt > step > run.
- IDLE:
  - `core_reset`=1, `PCenable`=0.
  - load → LOAD; halt or step → HALT; run → RUN.
- LOAD:
  - `rx_ready`=1, `core_reset`=1.
  - Entry clears `words_loaded` and sets byte phase to COUNT.
  - COUNT byte N gives word count N; N=0 means 2^IRAM_ADDR_BITS.
  - Then HI byte, then LO byte.
  - After each LO accept, next cycle: `iram_wen`=1 for exactly one cycle, `iram_din`={HI,LO}, `iram_wa`=`words_loaded`; `words_loaded` increments in that same cycle.
  - Bytes may arrive back-to-back; acceptance never stalls for the write.
  - On the cycle the final word's `iram_wen` is asserted, `rx_ready` drops, and the next state is HALT.
  - halt during LOAD aborts → IDLE. `words_loaded` holds completed words; a pending write still completes.
  - step and run are ignored in LOAD. load in LOAD restarts at COUNT.
- HALT:
  - `core_reset`=0, `PCenable`=0.
  - step → `PCenable`=1 for exactly one cycle.
  - run → RUN; load → LOAD.
- RUN:
  - `core_reset`=0. Tick counter cleared on entry.
  - Counter counts 0..TICK_DIV-1 and wraps. `PCenable`=1 for the one cycle after the count equals TICK_DIV-1.
  - TICK_DIV=1 gives `PCenable` continuously high.
  - halt → HALT; load → LOAD.
  - `PCenable`=0 from the cycle after either command is registered.
- `rx_ready`=0 outside LOAD; bytes offered there are not consumed.

## Timing
- Command registered at edge k → `state` and outputs change at edge k+1.
- Step: `PCenable` high during cycle k+1 only, one PC advance.
- Load write: LO accepted at edge k → `iram_wen` high for cycle k+1 → RAM written at edge k+2.
- Write address in `iram_wa` wraps modulo 2^IRAM_ADDR_BITS.
- Core exits reset on the first cycle in HALT/RUN; the core PC starts at 0.
- Async reset mid-load: all outputs return to reset values immediately. Partially written RAM content is left as-is.

## Test plan
- Load: bytes 02,12,34,AB,CD back-to-back → `iram_wen` pulses at wa=0 din=1234, then wa=1 din=ABCD; `words_loaded`=2; `state`=HALT; `core_reset`=0.
- Count 0: N=00 followed by 512 bytes → 256 writes, wa 0..255, then HALT; `words_loaded`=256.
- Step: in HALT, `cmd_step` held high 10 cycles → exactly one `PCenable` cycle; release and re-press → second pulse.
- Run: with TICK_DIV=4 → `PCenable` high every 4th cycle; `cmd_halt` → no further pulses, `state`=HALT. With TICK_DIV=1 → `PCenable` constantly 1.
- Abort: during LOAD after 1.5 words, `cmd_halt` → `words_loaded`=1, `state`=IDLE, `rx_ready`=0; same-cycle load+halt → LOAD restarts.
- Reset mid-load: assert `reset`=0 asynchronously between HI and LO → outputs at reset values before the next edge; subsequent load starts at COUNT.
